// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard unit: operand forwarding, load-use stall sequencing,
// branch flush, data-memory freeze, and saturating stall/flush event counters.
module pipe_hazard_ctrl #(
    parameter int unsigned AW         = 5,
    parameter int unsigned LU_BUBBLES = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    rs1D,
    input  logic [AW-1:0]    rs2D,
    input  logic [AW-1:0]    rs1E,
    input  logic [AW-1:0]    rs2E,
    input  logic [AW-1:0]    rdE,
    input  logic             reg_writeE,
    input  logic             loadE,
    input  logic             pc_srcE,
    input  logic [AW-1:0]    rdM,
    input  logic             reg_writeM,
    input  logic [AW-1:0]    rdW,
    input  logic             reg_writeW,
    input  logic             mem_busy,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
    output logic [1:0]       state
);

    localparam int unsigned LU_W = 3;
    localparam logic [1:0] RUN      = 2'b00;
    localparam logic [1:0] LU_WAIT  = 2'b01;
    localparam logic [1:0] MEM_WAIT = 2'b10;
    localparam logic [LU_W-1:0] LU_LOAD  = LU_W'(LU_BUBBLES - 1);
    localparam logic            LU_MULTI = (LU_BUBBLES > 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]      state_q, state_d, eff_state;
    logic [LU_W-1:0] lu_cnt_q, lu_cnt_d;
    logic            lu_hit;

    assign state  = state_q;
    assign lu_hit = loadE && reg_writeE && (rdE != '0) && ((rdE == rs1D) || (rdE == rs2D));

    // Forwarding select: memory stage wins over writeback; x0 never forwards
    always_comb begin
        forwardAE = 2'b00;
        forwardBE = 2'b00;
        if (reset) begin
            if (reg_writeM && (rdM != '0) && (rdM == rs1E))
                forwardAE = 2'b10;
            else if (reg_writeW && (rdW != '0) && (rdW == rs1E))
                forwardAE = 2'b01;
            if (reg_writeM && (rdM != '0) && (rdM == rs2E))
                forwardBE = 2'b10;
            else if (reg_writeW && (rdW != '0) && (rdW == rs2E))
                forwardBE = 2'b01;
        end
    end

    // Next-state and stall/flush decode; leaving MEM_WAIT acts as the resumed state
    always_comb begin
        state_d   = state_q;
        lu_cnt_d  = lu_cnt_q;
        stallF    = 1'b0;
        stallD    = 1'b0;
        stallE    = 1'b0;
        stallM    = 1'b0;
        flushD    = 1'b0;
        flushE    = 1'b0;
        eff_state = state_q;
        if (state_q == MEM_WAIT)
            eff_state = (lu_cnt_q != '0) ? LU_WAIT : RUN;

        if (!reset) begin
            flushD   = 1'b1;
            flushE   = 1'b1;
            state_d  = RUN;
            lu_cnt_d = '0;
        end else if (mem_busy) begin
            stallF  = 1'b1;
            stallD  = 1'b1;
            stallE  = 1'b1;
            stallM  = 1'b1;
            state_d = MEM_WAIT;
        end else if (pc_srcE) begin
            flushD   = 1'b1;
            flushE   = 1'b1;
            lu_cnt_d = '0;
            state_d  = RUN;
        end else begin
            case (eff_state)
                LU_WAIT: begin
                    stallF = 1'b1;
                    stallD = 1'b1;
                    flushE = 1'b1;
                    if (lu_cnt_q <= LU_W'(1)) begin
                        lu_cnt_d = '0;
                        state_d  = RUN;
                    end else begin
                        lu_cnt_d = lu_cnt_q - LU_W'(1);
                        state_d  = LU_WAIT;
                    end
                end
                default: begin
                    state_d = RUN;
                    if (lu_hit) begin
                        stallF   = 1'b1;
                        stallD   = 1'b1;
                        flushE   = 1'b1;
                        lu_cnt_d = LU_LOAD;
                        state_d  = LU_MULTI ? LU_WAIT : RUN;
                    end
                end
            endcase
        end
    end

    // State, bubble counter and saturating performance counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= RUN;
            lu_cnt_q     <= '0;
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            state_q  <= state_d;
            lu_cnt_q <= lu_cnt_d;
            if (stallF && (stall_cycles != CNT_MAX))
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (flushD && (flush_events != CNT_MAX))
                flush_events <= flush_events + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: per-cycle expectations are queued at drive
// time and compared against the DUT mid-cycle, with a bench-side counter tally.
module tb_pipe_hazard_ctrl;

    localparam int unsigned AW   = 5;
    localparam int unsigned LU_B = 3;
    localparam int unsigned CW   = 4;
    localparam int          SAT  = (1 << CW) - 1;
    localparam logic [1:0]  RUN  = 2'b00;
    localparam logic [1:0]  LUW  = 2'b01;
    localparam logic [1:0]  MW   = 2'b10;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic          reg_writeE, loadE, pc_srcE, reg_writeM, reg_writeW, mem_busy;
    logic          stallF, stallD, stallE, stallM, flushD, flushE;
    logic [1:0]    forwardAE, forwardBE, state;
    logic [CW-1:0] stall_cycles, flush_events;

    typedef struct packed {
        logic [3:0] stall;
        logic [1:0] flush;
        logic [1:0] st;
        logic [1:0] fa;
        logic [1:0] fb;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_sc   = 0;
    int   exp_fe   = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.AW(AW), .LU_BUBBLES(LU_B), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
        .reg_writeE(reg_writeE), .loadE(loadE), .pc_srcE(pc_srcE),
        .rdM(rdM), .reg_writeM(reg_writeM), .rdW(rdW), .reg_writeW(reg_writeW),
        .mem_busy(mem_busy),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .stall_cycles(stall_cycles), .flush_events(flush_events), .state(state)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        rs1D = '0; rs2D = '0; rs1E = '0; rs2E = '0; rdE = '0; rdM = '0; rdW = '0;
        reg_writeE = 1'b0; loadE = 1'b0; pc_srcE = 1'b0;
        reg_writeM = 1'b0; reg_writeW = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic assert_rst();
        reset  = 1'b0;
        exp_sc = 0;
        exp_fe = 0;
    endtask

    // Queue expectation for the current cycle, compare mid-cycle, advance one clock
    task automatic cyc(input string tag, input logic [3:0] s, input logic [1:0] f,
                       input logic [1:0] st, input logic [1:0] fa, input logic [1:0] fb);
        exp_t e;
        e = {s, f, st, fa, fb};
        sb_q.push_back(e);
        @(negedge clk);
        e = sb_q.pop_front();
        check_eq({tag, "/stall"}, 32'({stallF, stallD, stallE, stallM}), 32'(e.stall));
        check_eq({tag, "/flush"}, 32'({flushD, flushE}), 32'(e.flush));
        check_eq({tag, "/state"}, 32'(state), 32'(e.st));
        check_eq({tag, "/fwdA"}, 32'(forwardAE), 32'(e.fa));
        check_eq({tag, "/fwdB"}, 32'(forwardBE), 32'(e.fb));
        check_eq({tag, "/stall_cnt"}, 32'(stall_cycles), 32'(exp_sc));
        check_eq({tag, "/flush_cnt"}, 32'(flush_events), 32'(exp_fe));
        if (!reset) begin
            exp_sc = 0;
            exp_fe = 0;
        end else begin
            if (e.stall[3] && exp_sc < SAT) exp_sc++;
            if (e.flush[1] && exp_fe < SAT) exp_fe++;
        end
        @(posedge clk);
        #1;
    endtask

    // Reset with live forwarding/hazard inputs: outputs must still be forced
    task automatic do_reset();
        clear_inputs();
        assert_rst();
        rdM = 5'd5; reg_writeM = 1'b1; rdW = 5'd5; reg_writeW = 1'b1;
        rs1E = 5'd5; rs2E = 5'd5;
        cyc("rst_a", 4'b0000, 2'b11, RUN, 2'b00, 2'b00);
        mem_busy = 1'b1; pc_srcE = 1'b1;
        cyc("rst_b", 4'b0000, 2'b11, RUN, 2'b00, 2'b00);
        clear_inputs();
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        #1;
        do_reset();

        // Forwarding priority and x0 exclusion
        rdM = 5'd5; reg_writeM = 1'b1; rdW = 5'd5; reg_writeW = 1'b1; rs1E = 5'd5; rs2E = 5'd0;
        cyc("fwd_m", 4'b0000, 2'b00, RUN, 2'b10, 2'b00);
        rdM = 5'd0;
        cyc("fwd_w", 4'b0000, 2'b00, RUN, 2'b01, 2'b00);
        rdM = 5'd5; reg_writeM = 1'b0; rs2E = 5'd5;
        cyc("fwd_nowm", 4'b0000, 2'b00, RUN, 2'b01, 2'b01);
        rdM = 5'd0; reg_writeM = 1'b1; rdW = 5'd0; rs1E = 5'd0; rs2E = 5'd0;
        cyc("fwd_x0", 4'b0000, 2'b00, RUN, 2'b00, 2'b00);
        rdM = 5'd9; rdW = 5'd9; rs1E = 5'd4; rs2E = 5'd9;
        cyc("fwd_b", 4'b0000, 2'b00, RUN, 2'b00, 2'b10);
        clear_inputs();

        // Non-hits: destination x0, and non-load writer
        loadE = 1'b1; reg_writeE = 1'b1; rdE = 5'd0; rs1D = 5'd0;
        cyc("lu_x0", 4'b0000, 2'b00, RUN, 2'b00, 2'b00);
        loadE = 1'b0; rdE = 5'd7; rs2D = 5'd7;
        cyc("lu_noload", 4'b0000, 2'b00, RUN, 2'b00, 2'b00);
        clear_inputs();

        // Load-use: three bubbles
        do_reset();
        loadE = 1'b1; reg_writeE = 1'b1; rdE = 5'd7; rs2D = 5'd7;
        cyc("lu0", 4'b1100, 2'b01, RUN, 2'b00, 2'b00);
        clear_inputs();
        cyc("lu1", 4'b1100, 2'b01, LUW, 2'b00, 2'b00);
        cyc("lu2", 4'b1100, 2'b01, LUW, 2'b00, 2'b00);
        cyc("lu3", 4'b0000, 2'b00, RUN, 2'b00, 2'b00);
        check_eq("lu_total_stall", 32'(stall_cycles), 32'd3);

        // Branch beats a coincident load-use hit
        do_reset();
        loadE = 1'b1; reg_writeE = 1'b1; rdE = 5'd7; rs1D = 5'd7; pc_srcE = 1'b1;
        cyc("br_lu", 4'b0000, 2'b11, RUN, 2'b00, 2'b00);
        clear_inputs();
        cyc("br_after", 4'b0000, 2'b00, RUN, 2'b00, 2'b00);
        check_eq("br_flush_cnt", 32'(flush_events), 32'd1);
        check_eq("br_stall_cnt", 32'(stall_cycles), 32'd0);

        // Branch aborts an in-progress load-use sequence
        loadE = 1'b1; reg_writeE = 1'b1; rdE = 5'd3; rs1D = 5'd3;
        cyc("brlu0", 4'b1100, 2'b01, RUN, 2'b00, 2'b00);
        clear_inputs();
        pc_srcE = 1'b1;
        cyc("brlu1", 4'b0000, 2'b11, LUW, 2'b00, 2'b00);
        clear_inputs();
        cyc("brlu2", 4'b0000, 2'b00, RUN, 2'b00, 2'b00);

        // Memory freeze in LU_WAIT with one bubble left, then resume
        do_reset();
        loadE = 1'b1; reg_writeE = 1'b1; rdE = 5'd7; rs2D = 5'd7;
        cyc("mb_lu0", 4'b1100, 2'b01, RUN, 2'b00, 2'b00);
        clear_inputs();
        cyc("mb_lu1", 4'b1100, 2'b01, LUW, 2'b00, 2'b00);
        mem_busy = 1'b1; rdM = 5'd3; reg_writeM = 1'b1; rs1E = 5'd3;
        cyc("mb0", 4'b1111, 2'b00, LUW, 2'b10, 2'b00);
        for (int i = 1; i < 4; i++) begin
            pc_srcE = (i == 1);
            cyc("mbn", 4'b1111, 2'b00, MW, 2'b10, 2'b00);
        end
        clear_inputs();
        cyc("mb_ret", 4'b1100, 2'b01, MW, 2'b00, 2'b00);
        cyc("mb_done", 4'b0000, 2'b00, RUN, 2'b00, 2'b00);
        check_eq("mb_total_stall", 32'(stall_cycles), 32'd7);

        // Stall counter saturation
        do_reset();
        mem_busy = 1'b1;
        for (int i = 0; i < 20; i++)
            cyc("sat", 4'b1111, 2'b00, (i == 0) ? RUN : MW, 2'b00, 2'b00);
        mem_busy = 1'b0;
        cyc("sat_ret", 4'b0000, 2'b00, MW, 2'b00, 2'b00);
        cyc("sat_run", 4'b0000, 2'b00, RUN, 2'b00, 2'b00);
        check_eq("sat_stall_cnt", 32'(stall_cycles), 32'(SAT));

        // Reset mid MEM_WAIT, with mem_busy still high during reset
        mem_busy = 1'b1;
        cyc("rmw0", 4'b1111, 2'b00, RUN, 2'b00, 2'b00);
        cyc("rmw1", 4'b1111, 2'b00, MW, 2'b00, 2'b00);
        assert_rst();
        cyc("rmw_rst", 4'b0000, 2'b11, RUN, 2'b00, 2'b00);
        reset = 1'b1; mem_busy = 1'b0;
        cyc("rmw_rel", 4'b0000, 2'b00, RUN, 2'b00, 2'b00);

        // Reset mid LU_WAIT
        loadE = 1'b1; reg_writeE = 1'b1; rdE = 5'd7; rs1D = 5'd7;
        cyc("rlu0", 4'b1100, 2'b01, RUN, 2'b00, 2'b00);
        clear_inputs();
        cyc("rlu1", 4'b1100, 2'b01, LUW, 2'b00, 2'b00);
        assert_rst();
        cyc("rlu_rst", 4'b0000, 2'b11, RUN, 2'b00, 2'b00);
        reset = 1'b1;
        cyc("rlu_rel", 4'b0000, 2'b00, RUN, 2'b00, 2'b00);
        cyc("rlu_idle", 4'b0000, 2'b00, RUN, 2'b00, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter AW, default 5, register-address width (4 for RV32E).
REQ-002 SHALL have parameter LU_BUBBLES, default 1, load-use bubble count, legal 1..7.
REQ-003 SHALL have parameter CNT_W, default 16, performance-counter width.
REQ-004 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports rs1D, rs2D, input, AW, decode-stage source registers.
REQ-007 SHALL have ports rs1E, rs2E, rdE, input, AW, execute-stage sources/destination.
REQ-008 SHALL have ports reg_writeE, loadE, pc_srcE, input, 1, execute writes rd / is a load / redirects PC.
REQ-009 SHALL have ports rdM, input, AW and reg_writeM, input, 1, memory-stage destination.
REQ-010 SHALL have ports rdW, input, AW and reg_writeW, input, 1, writeback-stage destination.
REQ-011 SHALL have port mem_busy, input, 1, data memory not ready; pipeline must freeze.
REQ-012 SHALL have ports stallF, stallD, stallE, stallM, output, 1; 1 = hold that stage register.
REQ-013 SHALL have ports flushD, flushE, output, 1; 1 = clear that stage register to a bubble.
REQ-014 SHALL have ports forwardAE, forwardBE, output, 2; 00 register file, 01 writeback, 10 memory.
REQ-015 SHALL have ports stall_cycles, flush_events, output, CNT_W, saturating performance counters.
REQ-016 SHALL have port state, output, 2; 00 RUN, 01 LU_WAIT, 10 MEM_WAIT.

Function
REQ-017 forwardAE SHALL be 10 if reg_writeM, rdM!=0 and rdM==rs1E; else 01 if reg_writeW, rdW!=0 and rdW==rs1E; else 00; forwardBE identically with rs2E; purely combinational, also valid during stalls.
REQ-018 Load-use hit SHALL be defined as loadE, reg_writeE, rdE!=0 and (rdE==rs1D or rdE==rs2D).
REQ-019 Priority SHALL be: mem_busy > pc_srcE > load-use > none.
REQ-020 While mem_busy=1 (any state): stallF=stallD=stallE=stallM=1, flushD=flushE=0; next state MEM_WAIT; LU counter holds its value.
REQ-021 MEM_WAIT with mem_busy=0 SHALL return to LU_WAIT if LU counter non-zero, else RUN; outputs that cycle as evaluated in the returned-to state.
REQ-022 pc_srcE=1 with mem_busy=0 SHALL give flushD=flushE=1, all stalls 0, LU counter cleared, next state RUN; a coincident load-use hit is ignored.
REQ-023 RUN with load-use hit SHALL give stallF=stallD=1, flushE=1, stallE=stallM=0, load LU counter to LU_BUBBLES-1; next state LU_WAIT if LU_BUBBLES>1, else RUN.
REQ-024 LU_WAIT SHALL assert stallF=stallD=flushE=1 and decrement counter each cycle; exit to RUN the cycle counter reaches 0 (total stall exactly LU_BUBBLES cycles).
REQ-025 RUN, no event: all stall/flush outputs 0.
REQ-026 stall_cycles SHALL increment on every cycle stallF=1; flush_events on every cycle flushD=1; both saturate at 2^CNT_W-1 and do not wrap.
REQ-027 stall/flush outputs SHALL be combinational from state, counter and inputs (zero latency); no input-to-output register.

Reset
REQ-028 reset=0 SHALL immediately force state RUN, LU counter 0, stall_cycles=flush_events=0.
REQ-029 While reset=0: stall outputs 0, flushD=flushE=1, forwardAE=forwardBE=00.
REQ-030 Reset assertion mid-LU_WAIT or mid-MEM_WAIT SHALL abort the sequence; first cycle after release is RUN with no residual stall.

Verification
REQ-031 rdM=5,reg_writeM=1,rdW=5,reg_writeW=1,rs1E=5,rs2E=0 -> forwardAE=10, forwardBE=00; same with rdM=0 -> forwardAE=01.
REQ-032 LU_BUBBLES=3, loadE=1,reg_writeE=1,rdE=7,rs2D=7 one cycle -> stallF=stallD=flushE=1 for exactly 3 cycles, state 00,01,01,00; stall_cycles=3.
REQ-033 Load-use hit and pc_srcE=1 same cycle -> flushD=flushE=1, stallF=0, state RUN, flush_events=1, stall_cycles=0.
REQ-034 mem_busy=1 for 4 cycles during LU_WAIT with counter 1 -> all four stalls 1 for 4 cycles, no flush; then 1 more LU cycle; stall_cycles=+5.
REQ-035 CNT_W=4, hold stall 20 cycles -> stall_cycles stops at 15.
REQ-036 reset pulsed low in MEM_WAIT -> counters 0, flushD=flushE=1 during reset, RUN on release with all stalls 0.
